// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front panel: LCD glyph codes,
// operator-to-glyph mapping, FSM state and switch classification enums.
package calc_pkg;

  localparam logic [7:0] LCD_BLK = 8'h20;
  localparam logic [7:0] LCD_SUM = 8'h2B;
  localparam logic [7:0] LCD_SUB = 8'h2D;
  localparam logic [7:0] LCD_MUL = 8'hD7;
  localparam logic [7:0] LCD_DIV = 8'h2F;
  localparam logic [7:0] LCD_REM = 8'hF7;
  localparam logic [7:0] LCD_POW = 8'h5E;
  localparam logic [7:0] LCD_FAC = 8'h21;
  localparam logic [7:0] LCD_EQU = 8'h3D;
  localparam logic [7:0] LCD_ERR = 8'h45;
  localparam logic [7:0] LCD_UNK = 8'h3F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_OP,
    CLS_MULTI
  } class_t;

  function automatic logic [7:0] op_to_lcd(input logic [3:0] idx);
    case (idx)
      4'd0:    op_to_lcd = LCD_SUM;
      4'd1:    op_to_lcd = LCD_SUB;
      4'd2:    op_to_lcd = LCD_MUL;
      4'd3:    op_to_lcd = LCD_DIV;
      4'd4:    op_to_lcd = LCD_REM;
      4'd5:    op_to_lcd = LCD_POW;
      4'd6:    op_to_lcd = LCD_FAC;
      4'd7:    op_to_lcd = LCD_EQU;
      default: op_to_lcd = LCD_UNK;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a candidate/counter debouncer; o_stable
// takes a new vector only after CYC consecutive identical synchronised samples.
module sw_debounce #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CYC   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int unsigned    CW      = $clog2(CYC + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CYC);
  localparam logic [CW-1:0]  LOAD_AT = CW'(CYC - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt;

  // The sample that differs from the candidate is counted as its first
  // observation, so the CYC-th matching sample loads stable directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= CW'(1);
      end else if (r_cnt == LOAD_AT) begin
        r_stable <= r_cand;
        r_cnt    <= CNT_MAX;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/switch_op_select.sv
// Operator selector: debounced DIP bank -> one-hot operator offered over valid/ack,
// plus LED/LCD display. Define OP_STICKY_EN to keep the last accepted op on display when idle.
module switch_op_select
  import calc_pkg::*;
#(
  parameter int unsigned N_SW         = 8,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SW-1:0]         i_sw_dip,
  input  logic                    i_op_ack,
  output logic                    o_op_valid,
  output logic [$clog2(N_SW)-1:0] o_op_code,
  output logic                    o_err,
  output logic [N_SW-1:0]         o_led,
  output logic [7:0]              o_lcd_char
);

  localparam int unsigned CW = $clog2(N_SW);

  logic [N_SW-1:0] w_stable;
  logic            w_nonzero;
  logic            w_onehot;
  logic [CW-1:0]   w_idx;
  class_t          w_class;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_code;
  logic            r_err;
  logic [N_SW-1:0] r_led;
  logic [7:0]      r_lcd;
  logic [N_SW-1:0] w_led_nxt;
  logic [7:0]      w_lcd_nxt;

`ifdef OP_STICKY_EN
  logic [CW-1:0]   r_last;
  logic            r_last_vld;
`endif

  sw_debounce #(
    .WIDTH (N_SW),
    .CYC   (DEBOUNCE_CYC)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (i_sw_dip),
    .o_stable (w_stable)
  );

  // OR-encode the index: only meaningful when exactly one bit is set.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      if (w_stable[i]) w_idx = w_idx | CW'(N_SW - 1 - i);
    end
    w_nonzero = |w_stable;
    w_onehot  = w_nonzero && ((w_stable & (w_stable - N_SW'(1))) == '0);
    if (!w_nonzero)    w_class = CLS_NONE;
    else if (w_onehot) w_class = CLS_OP;
    else               w_class = CLS_MULTI;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_code  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_class == CLS_OP) r_code <= w_idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_class == CLS_OP) w_state_nxt = S_PEND;
      S_PEND: begin
        if (i_op_ack)                             w_state_nxt = S_HOLD;
        else if (!(w_onehot && w_idx == r_code))  w_state_nxt = S_IDLE;
      end
      S_HOLD:  if (!w_nonzero) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_op_valid = (r_state == S_PEND);
    w_led_nxt  = '0;
    w_lcd_nxt  = LCD_BLK;
    case (r_state)
      S_PEND, S_HOLD: begin
        w_led_nxt = N_SW'(1) << (CW'(N_SW - 1) - r_code);
        w_lcd_nxt = op_to_lcd(4'(r_code));
      end
      default: begin
        if (w_class == CLS_MULTI) begin
          w_lcd_nxt = LCD_ERR;
        end
`ifdef OP_STICKY_EN
        else if (r_last_vld) begin
          w_led_nxt = N_SW'(1) << (CW'(N_SW - 1) - r_last);
          w_lcd_nxt = op_to_lcd(4'(r_last));
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
      r_led <= '0;
      r_lcd <= LCD_BLK;
    end else begin
      r_err <= (w_class == CLS_MULTI);
      r_led <= w_led_nxt;
      r_lcd <= w_lcd_nxt;
    end
  end

`ifdef OP_STICKY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else if (r_state == S_PEND && i_op_ack) begin
      r_last     <= r_code;
      r_last_vld <= 1'b1;
    end
  end
`endif

  assign o_op_code  = r_code;
  assign o_err      = r_err;
  assign o_led      = r_led;
  assign o_lcd_char = r_lcd;

endmodule

// File: tb/tb_switch_op_select.sv
// Directed bench for switch_op_select (N_SW=8, DEBOUNCE_CYC=4); expectations
// follow OP_STICKY_EN so the same file serves both builds.
module tb_switch_op_select;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       ack;
  logic       valid;
  logic [2:0] code;
  logic       err;
  logic [7:0] led;
  logic [7:0] lcd;

  int n_checks;
  int n_fail;

`ifdef OP_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  switch_op_select #(
    .N_SW         (8),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_sw_dip   (sw),
    .i_op_ack   (ack),
    .o_op_valid (valid),
    .o_op_code  (code),
    .o_err      (err),
    .o_led      (led),
    .o_lcd_char (lcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; sw = 8'h80; ack = 1'b0;
    tick(3);
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL rst_valid: got %0b want 0", valid); end
    n_checks++; if (code !== 3'd0)   begin n_fail++; $display("FAIL rst_code: got %0d want 0", code); end
    n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL rst_err: got %0b want 0", err); end
    n_checks++; if (led !== 8'h00)   begin n_fail++; $display("FAIL rst_led: got %h want 00", led); end
    n_checks++; if (lcd !== 8'h20)   begin n_fail++; $display("FAIL rst_lcd: got %h want 20", lcd); end
    rst = 1'b1;
    tick(6);
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL rst_early: got %0b want 0", valid); end
    tick(1);
    n_checks++; if (valid !== 1'b1)  begin n_fail++; $display("FAIL rst_offer: got %0b want 1", valid); end
    n_checks++; if (code !== 3'd0)   begin n_fail++; $display("FAIL rst_offer_code: got %0d want 0", code); end
  endtask

  task automatic test_latency();
    sw = 8'h00;
    tick(10);
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL lat_withdraw: got %0b want 0", valid); end
    sw = 8'h10;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL lat_early c%0d: got %0b want 0", k, valid); end
    end
    tick(1);
    n_checks++; if (valid !== 1'b1)  begin n_fail++; $display("FAIL lat_valid: got %0b want 1", valid); end
    n_checks++; if (code !== 3'd3)   begin n_fail++; $display("FAIL lat_code: got %0d want 3", code); end
    tick(1);
    n_checks++; if (lcd !== 8'h2F)   begin n_fail++; $display("FAIL lat_lcd: got %h want 2f", lcd); end
    n_checks++; if (led !== 8'h10)   begin n_fail++; $display("FAIL lat_led: got %h want 10", led); end
    for (int k = 0; k < 20; k++) begin
      tick(1);
      n_checks++; if (valid !== 1'b1 || code !== 3'd3) begin n_fail++; $display("FAIL lat_hold c%0d: got v=%0b c=%0d want v=1 c=3", k, valid, code); end
    end
    pulse_ack();
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL ack_drop: got %0b want 0", valid); end
    tick(1);
    n_checks++; if (lcd !== 8'h2F)   begin n_fail++; $display("FAIL ack_lcd: got %h want 2f", lcd); end
  endtask

  task automatic test_bounce();
    sw = 8'h00;
    tick(10);
    pulse_ack();
    tick(1);
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL idle_ack: got %0b want 0", valid); end
    for (int c = 0; c < 30; c++) begin
      sw = (((c / 3) % 2) == 0) ? 8'h01 : 8'h00;
      tick(1);
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bounce c%0d: got %0b want 0", c, valid); end
    end
    sw = 8'h00;
    tick(10);
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL bounce_end: got %0b want 0", valid); end
    n_checks++; if (lcd !== (STICKY ? 8'h2F : 8'h20)) begin n_fail++; $display("FAIL bounce_lcd: got %h want %h", lcd, STICKY ? 8'h2F : 8'h20); end
  endtask

  task automatic test_multi();
    sw = 8'h41;
    tick(10);
    n_checks++; if (err !== 1'b1)    begin n_fail++; $display("FAIL multi_err: got %0b want 1", err); end
    n_checks++; if (lcd !== 8'h45)   begin n_fail++; $display("FAIL multi_lcd: got %h want 45", lcd); end
    n_checks++; if (led !== 8'h00)   begin n_fail++; $display("FAIL multi_led: got %h want 00", led); end
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL multi_valid: got %0b want 0", valid); end
    sw = 8'h40;
    tick(10);
    n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL single_err: got %0b want 0", err); end
    n_checks++; if (valid !== 1'b1)  begin n_fail++; $display("FAIL single_valid: got %0b want 1", valid); end
    n_checks++; if (code !== 3'd1)   begin n_fail++; $display("FAIL single_code: got %0d want 1", code); end
    n_checks++; if (lcd !== 8'h2D)   begin n_fail++; $display("FAIL single_lcd: got %h want 2d", lcd); end
    n_checks++; if (led !== 8'h40)   begin n_fail++; $display("FAIL single_led: got %h want 40", led); end
    pulse_ack();
    sw = 8'h00;
    tick(10);
  endtask

  task automatic test_hold_release();
    sw = 8'h80;
    tick(10);
    n_checks++; if (valid !== 1'b1 || code !== 3'd0) begin n_fail++; $display("FAIL hold_offer: got v=%0b c=%0d want v=1 c=0", valid, code); end
    pulse_ack();
    sw = 8'h04;
    tick(10);
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL hold_ignore: got %0b want 0", valid); end
    n_checks++; if (lcd !== 8'h2B)   begin n_fail++; $display("FAIL hold_lcd: got %h want 2b", lcd); end
    n_checks++; if (led !== 8'h80)   begin n_fail++; $display("FAIL hold_led: got %h want 80", led); end
    sw = 8'h00;
    tick(10);
    n_checks++; if (lcd !== (STICKY ? 8'h2B : 8'h20)) begin n_fail++; $display("FAIL release_lcd: got %h want %h", lcd, STICKY ? 8'h2B : 8'h20); end
    n_checks++; if (led !== (STICKY ? 8'h80 : 8'h00)) begin n_fail++; $display("FAIL release_led: got %h want %h", led, STICKY ? 8'h80 : 8'h00); end
    sw = 8'h04;
    tick(10);
    n_checks++; if (valid !== 1'b1 || code !== 3'd5) begin n_fail++; $display("FAIL reoffer: got v=%0b c=%0d want v=1 c=5", valid, code); end
    n_checks++; if (lcd !== 8'h5E)   begin n_fail++; $display("FAIL reoffer_lcd: got %h want 5e", lcd); end
    pulse_ack();
    sw = 8'h00;
    tick(10);
  endtask

  task automatic test_corner();
    sw = 8'h02;
    tick(10);
    n_checks++; if (valid !== 1'b1 || code !== 3'd6) begin n_fail++; $display("FAIL wd_offer: got v=%0b c=%0d want v=1 c=6", valid, code); end
    n_checks++; if (lcd !== 8'h21)   begin n_fail++; $display("FAIL wd_offer_lcd: got %h want 21", lcd); end
    sw = 8'h00;
    tick(10);
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL wd_drop: got %0b want 0", valid); end
    n_checks++; if (lcd !== (STICKY ? 8'h5E : 8'h20)) begin n_fail++; $display("FAIL wd_lcd: got %h want %h", lcd, STICKY ? 8'h5E : 8'h20); end

    sw = 8'h20;
    tick(10);
    n_checks++; if (valid !== 1'b1 || code !== 3'd2) begin n_fail++; $display("FAIL co_offer: got v=%0b c=%0d want v=1 c=2", valid, code); end
    sw = 8'h00;
    tick(6);
    n_checks++; if (valid !== 1'b1)  begin n_fail++; $display("FAIL co_pend: got %0b want 1", valid); end
    pulse_ack();
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL co_valid: got %0b want 0", valid); end
    tick(1);
    n_checks++; if (lcd !== 8'hD7)   begin n_fail++; $display("FAIL co_hold_lcd: got %h want d7", lcd); end
    tick(1);
    n_checks++; if (lcd !== (STICKY ? 8'hD7 : 8'h20)) begin n_fail++; $display("FAIL co_idle_lcd: got %h want %h", lcd, STICKY ? 8'hD7 : 8'h20); end

    sw = 8'h08;
    tick(10);
    n_checks++; if (valid !== 1'b1 || code !== 3'd4) begin n_fail++; $display("FAIL rp_offer: got v=%0b c=%0d want v=1 c=4", valid, code); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL rp_valid: got %0b want 0", valid); end
    n_checks++; if (code !== 3'd0)   begin n_fail++; $display("FAIL rp_code: got %0d want 0", code); end
    n_checks++; if (lcd !== 8'h20)   begin n_fail++; $display("FAIL rp_lcd: got %h want 20", lcd); end
    tick(1);
    rst = 1'b1;
    tick(6);
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL rp_early: got %0b want 0", valid); end
    tick(1);
    n_checks++; if (valid !== 1'b1 || code !== 3'd4) begin n_fail++; $display("FAIL rp_reoffer: got v=%0b c=%0d want v=1 c=4", valid, code); end
    tick(1);
    n_checks++; if (lcd !== 8'hF7)   begin n_fail++; $display("FAIL rp_lcd2: got %h want f7", lcd); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; sw = 8'h00; ack = 1'b0;
    test_reset();
    test_latency();
    test_bounce();
    test_multi();
    test_hold_release();
    test_corner();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
